// File: rtl/sequenciador_rpn.sv
// RPN calculator sequencer: loads operand A, operand B and the opcode on enter presses, then captures the ALU result.
// Define SEQ_RPN_ENCADEAMENTO_EN to chain results: a press while showing a result reuses it as operand A.
module sequenciador_rpn #(
   parameter int LARGURA    = 8,
   parameter int LARGURA_OP = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enter,
   input  logic [LARGURA-1:0]    dado_in,
   input  logic [LARGURA_OP-1:0] op_in,
   input  logic [LARGURA-1:0]    resultado_ula,
   output logic [1:0]            estado,
   output logic [LARGURA-1:0]    operando_a,
   output logic [LARGURA-1:0]    operando_b,
   output logic [LARGURA_OP-1:0] opcode,
   output logic                  ula_valido,
   output logic [LARGURA-1:0]    resultado,
   output logic                  res_valido
);

   typedef enum logic [1:0] {
      CARREGA_A  = 2'b00,
      CARREGA_B  = 2'b01,
      CARREGA_OP = 2'b10,
      MOSTRA_RES = 2'b11
   } estado_t;

   estado_t estado_q;
   logic    s1, s2, prev;
   logic    pulso;

   // Synchronizer and history flops reset high so a button held through reset
   // must be released and pressed again before it produces a pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1   <= 1'b1;
         s2   <= 1'b1;
         prev <= 1'b1;
      end else begin
         s1   <= enter;
         s2   <= s1;
         prev <= s2;
      end
   end

   assign pulso = s2 & ~prev;

   // ula_valido is a one-cycle strobe with no back-pressure: the ALU result is
   // taken unconditionally on the edge that ends the strobe cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q   <= CARREGA_A;
         operando_a <= '0;
         operando_b <= '0;
         opcode     <= '0;
         ula_valido <= 1'b0;
         resultado  <= '0;
         res_valido <= 1'b0;
      end else begin
         case (estado_q)
            CARREGA_A: begin
               if (pulso) begin
                  operando_a <= dado_in;
                  res_valido <= 1'b0;
                  estado_q   <= CARREGA_B;
               end
            end
            CARREGA_B: begin
               if (pulso) begin
                  operando_b <= dado_in;
                  estado_q   <= CARREGA_OP;
               end
            end
            CARREGA_OP: begin
               if (pulso) begin
                  opcode     <= op_in;
                  ula_valido <= 1'b1;
                  estado_q   <= MOSTRA_RES;
               end
            end
            MOSTRA_RES: begin
               // Pulses are spaced so they never land in the strobe cycle.
               if (ula_valido) begin
                  resultado  <= resultado_ula;
                  res_valido <= 1'b1;
                  ula_valido <= 1'b0;
               end else if (pulso) begin
`ifdef SEQ_RPN_ENCADEAMENTO_EN
                  operando_a <= resultado;
                  estado_q   <= CARREGA_B;
`else
                  estado_q   <= CARREGA_A;
`endif
               end
            end
            default: estado_q <= CARREGA_A;
         endcase
      end
   end

   assign estado = estado_q;

endmodule

// File: doc/sequenciador_rpn.md
# sequenciador_rpn

Control stage of the RPN calculator path that feeds the ALU. It turns operator `enter` presses into a 2-bit sequencer state: load A, load B, load operation, show result. It latches the switch values into operand and opcode registers and presents them to the combinational ALU. It then captures the ALU result with a one-cycle strobe. The state is exported so the display/LED decoding downstream can follow the sequence.

## Interface
- `LARGURA`, 8, operand/result width in bits
- `LARGURA_OP`, 3, opcode width in bits

Ports:
- `clk`  input  1  system clock; all logic updates on the rising edge
- `reset`  input  1  synchronous, active-high reset
- `enter`  input  1  debounced button level, active-high, asynchronous to `clk`
- `dado_in`  input  LARGURA  switch value for operands
- `op_in`  input  LARGURA_OP  switch value for the opcode
- `resultado_ula`  input  LARGURA  combinational ALU result for (`operando_a`, `operando_b`, `opcode`)
- `estado`  output  2  current sequencer state
- `operando_a`  output  LARGURA  registered operand A to the ALU
- `operando_b`  output  LARGURA  registered operand B to the ALU
- `opcode`  output  LARGURA_OP  registered opcode to the ALU
- `ula_valido`  output  1  one-cycle capture strobe
- `resultado`  output  LARGURA  registered captured result
- `res_valido`  output  1  `resultado` is valid for the current operation

## Operation
- **Input chain:** `enter` passes through a 2-flop synchronizer (`s1`, `s2`) and then a history flop `prev`.
  - `pulso = s2 & ~prev`.
  - All three flops reset to 1, so an `enter` held high through reset produces no pulse until it is released and pressed again.
- **States:** 00 CARREGA_A, 01 CARREGA_B, 10 CARREGA_OP, 11 MOSTRA_RES.
- **CARREGA_A** + `pulso`:
  - `operando_a <= dado_in`, `res_valido <= 0`.
  - Next state is CARREGA_B.
- **CARREGA_B** + `pulso`:
  - `operando_b <= dado_in`.
  - Next state is CARREGA_OP.
- **CARREGA_OP** + `pulso`:
  - `opcode <= op_in`.
  - Next state is MOSTRA_RES, and `ula_valido <= 1` on the same edge.
- **MOSTRA_RES:**
  - While `ula_valido` is high, the next edge does `resultado <= resultado_ula`, `res_valido <= 1`, `ula_valido <= 0`.
  - A `pulso` in this state follows the Configuration rules.
- **No pulse:** state and registers hold.
- **Width rule:** no arithmetic in this block. Values are copied at full width with no truncation or extension.
- **Reset values:** `estado` 00; `operando_a`, `operando_b`, `resultado` 0; `opcode` 0; `ula_valido` 0; `res_valido` 0.
- **Reset mid-operation:** reset has priority over everything. The sequence restarts in CARREGA_A, and any pending capture is discarded.
- `estado` is the only encoded state. There are no illegal encodings.

## Timing
- **Press latency:** registers and `estado` update on the 3rd rising edge at which `enter` is sampled high.
- **Pulse spacing:** consecutive pulses are at least 2 cycles apart, so a pulse never coincides with the `ula_valido` cycle.
- **Result capture:** on entering MOSTRA_RES at edge E:
  - `ula_valido` is high for exactly the cycle E..E+1.
  - `resultado` and `res_valido` update at E+1.
- **ALU path:** `resultado_ula` must settle within one cycle of `operando_a`, `operando_b` and `opcode` becoming stable. The operands are stable from before E.
- **Hold:** `res_valido` stays high until the next CARREGA_A load (or until reset).

## Configuration
- `SEQ_RPN_ENCADEAMENTO_EN` defined (RPN chaining):
  - A pulse in MOSTRA_RES sets `operando_a <= resultado` and goes to CARREGA_B.
  - `operando_b` and `opcode` are unchanged until reloaded.
  - `res_valido` stays 1 until the next capture overwrites it.
- Not defined:
  - A pulse in MOSTRA_RES goes to CARREGA_A.
  - The operand registers are untouched until they are reloaded.

## Test plan
- **Reset:** assert `reset` for 2 cycles with `enter` high, then hold `enter` high for 10 cycles -> all outputs are at reset values, `estado` stays 00, no state change.
- **Full sequence:** press with `dado_in`=0x12, press with `dado_in`=0x34, press with `op_in`=3'b001, model ALU = A+B -> `estado` goes 00→01→10→11; `ula_valido` is high for 1 cycle; `resultado`=0x46 with `res_valido`=1 one edge later.
- **Latency:** raise `enter` and count edges -> `estado` changes exactly on the 3rd sampling edge; holding `enter` for 20 cycles gives exactly one transition.
- **Chaining, without the macro:** from MOSTRA_RES (`resultado`=0x46), press -> `estado`=00, `operando_a` still 0x12, `res_valido` stays 1 until the next A load.
- **Chaining, with `SEQ_RPN_ENCADEAMENTO_EN`:** same point, press -> `estado`=01, `operando_a`=0x46; then B=0x02, op=add -> `resultado`=0x48.
- **Reset mid-operation:** pulse `reset` in the `ula_valido` cycle -> `resultado` stays 0, `res_valido`=0, `estado`=00 on the next edge.
